// File: rtl/tester_gtx_seq.sv
// GTX pattern-generator test sequencer: sweeps interval length, runs N bursts per step.
// Optional watchdog on burst activity: define TESTER_GTX_SEQ_TIMEOUT_EN.
module tester_gtx_seq #(
  parameter int GAP_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        usrclk,
  input  logic        usrrst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        link_ready,
  input  logic [7:0]  len_start,
  input  logic [7:0]  len_end,
  input  logic [7:0]  len_step,
  input  logic [15:0] burst_num,
  input  logic [1:0]  gen_txchar,
  output logic [7:0]  test_len_ctrl,
  output logic        test_run_ctrl,
  output logic        busy,
  output logic        done,
  output logic        err_link,
  output logic        err_timeout,
  output logic [7:0]  step_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_LINK, S_RUN, S_DRAIN, S_GAP, S_FIN, S_ERR
  } state_t;

  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        r_state;
  logic [1:0]    r_txc;
  logic [7:0]    r_len;
  logic [7:0]    r_lend;
  logic [7:0]    r_lstep;
  logic [15:0]   r_bnum;
  logic [15:0]   r_bcnt;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_step;
  logic          r_run;
  logic          r_busy;
  logic          r_done;
  logic          r_err_link;
  logic          r_err_to;

  logic          w_bstart;
  logic          w_bend;
  logic          w_active;
  logic          w_link_loss;
  logic          w_to;
  logic          w_gap_end;
  logic          w_last;
  logic [15:0]   w_bcnt_nxt;
  logic [8:0]    w_nxt;

  assign w_bstart    = (r_txc == 2'b01) && (gen_txchar == 2'b00);
  assign w_bend      = (r_txc == 2'b00) && (gen_txchar == 2'b01);
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_link_loss = w_active && !link_ready;
  assign w_bcnt_nxt  = r_bcnt + 16'd1;
  assign w_nxt       = {1'b0, r_len} + {1'b0, r_lstep};
  assign w_gap_end   = (r_gap == GW'(GAP_CYCLES - 1));
  // 9-bit sum catches carry past 255 as well as overshooting len_end
  assign w_last      = (r_lstep == 8'd0) || w_nxt[8] ||
                       (w_nxt > {1'b0, r_lend});

`ifdef TESTER_GTX_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wd;

  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      r_wd <= '0;
    end else if (!w_active || w_bstart || w_bend) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + TW'(1);
    end
  end

  assign w_to = w_active && (r_wd == TW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES == 0);
  assign w_to        = 1'b0;
`endif

  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      r_txc <= 2'b01;
    end else begin
      r_txc <= gen_txchar;
    end
  end

  always_ff @(posedge usrclk or negedge usrrst_n) begin
    if (!usrrst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_lend     <= '0;
      r_lstep    <= '0;
      r_bnum     <= '0;
      r_bcnt     <= '0;
      r_gap      <= '0;
      r_step     <= '0;
      r_run      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err_link <= 1'b0;
      r_err_to   <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_run   <= 1'b0;
      r_busy  <= 1'b0;
    end else if (w_link_loss) begin
      r_state    <= S_ERR;
      r_run      <= 1'b0;
      r_err_link <= 1'b1;
    end else if (w_to) begin
      r_state  <= S_ERR;
      r_run    <= 1'b0;
      r_err_to <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_WAIT_LINK;
            r_len      <= len_start;
            r_lend     <= len_end;
            r_lstep    <= len_step;
            r_bnum     <= (burst_num == 16'd0) ? 16'd1 : burst_num;
            r_bcnt     <= '0;
            r_step     <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_err_link <= 1'b0;
            r_err_to   <= 1'b0;
          end
        end
        S_WAIT_LINK: begin
          if (link_ready) begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_bstart) begin
            r_bcnt <= w_bcnt_nxt;
            if (w_bcnt_nxt == r_bnum) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_bend) begin
            r_state <= S_GAP;
            r_run   <= 1'b0;
            r_gap   <= '0;
            if (r_step != 8'hFF) begin
              r_step <= r_step + 8'd1;
            end
          end
        end
        S_GAP: begin
          if (!w_gap_end) begin
            r_gap <= r_gap + GW'(1);
          end else if (w_last) begin
            r_state <= S_FIN;
          end else begin
            r_state <= S_WAIT_LINK;
            r_len   <= w_nxt[7:0];
            r_bcnt  <= '0;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign test_len_ctrl = r_len;
  assign test_run_ctrl = r_run;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err_link      = r_err_link;
  assign err_timeout   = r_err_to;
  assign step_cnt      = r_step;

endmodule

// File: tb/tb_tester_gtx_seq.sv
// Scoreboard bench for tester_gtx_seq with a behavioural burst generator.
// Define TESTER_GTX_SEQ_TIMEOUT_EN to exercise the watchdog path.
module tb_tester_gtx_seq;

  logic        usrclk = 1'b0;
  logic        usrrst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        link_ready = 1'b0;
  logic [7:0]  len_start = '0;
  logic [7:0]  len_end = '0;
  logic [7:0]  len_step = '0;
  logic [15:0] burst_num = '0;
  logic [1:0]  gen_txchar = 2'b01;
  logic [7:0]  test_len_ctrl;
  logic        test_run_ctrl;
  logic        busy;
  logic        done;
  logic        err_link;
  logic        err_timeout;
  logic [7:0]  step_cnt;

  tester_gtx_seq #(
    .GAP_CYCLES(64),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .usrclk(usrclk),
    .usrrst_n(usrrst_n),
    .start(start),
    .abort(abort),
    .link_ready(link_ready),
    .len_start(len_start),
    .len_end(len_end),
    .len_step(len_step),
    .burst_num(burst_num),
    .gen_txchar(gen_txchar),
    .test_len_ctrl(test_len_ctrl),
    .test_run_ctrl(test_run_ctrl),
    .busy(busy),
    .done(done),
    .err_link(err_link),
    .err_timeout(err_timeout),
    .step_cnt(step_cnt)
  );

  always #5 usrclk = ~usrclk;

  typedef struct {
    int len;
    int bursts;
  } step_t;

  typedef struct {
    int done;
    int el;
    int et;
    int steps;
    int len;
    int gap;
  } stat_t;

  step_t stq[$];
  stat_t sq[$];
  step_t s;
  stat_t st;
  int checks = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_step(input int l, input int b);
    step_t x;
    x.len = l;
    x.bursts = b;
    stq.push_back(x);
  endtask

  task automatic push_stat(input int d, input int el, input int et,
                           input int n, input int l, input int g);
    stat_t x;
    x.done = d;
    x.el = el;
    x.et = et;
    x.steps = n;
    x.len = l;
    x.gap = g;
    sq.push_back(x);
  endtask

  // Generator model: 2 idle chars (01) then a 4-char burst (00) while run is high;
  // a started burst always completes.
  int nb = 0;
  bit hold = 1'b0;
  bit in_b = 1'b0;
  int bl = 0;
  int ic = 0;

  initial forever begin
    @(posedge usrclk);
    #1;
    if (!usrrst_n) begin
      in_b = 1'b0;
      ic = 0;
      gen_txchar = 2'b01;
    end else if (in_b) begin
      bl++;
      if (bl == 4) begin
        in_b = 1'b0;
        ic = 0;
        gen_txchar = 2'b01;
      end
    end else if (test_run_ctrl && !hold) begin
      if (ic == 2) begin
        in_b = 1'b1;
        bl = 0;
        gen_txchar = 2'b00;
        nb++;
      end else begin
        ic++;
      end
    end else begin
      ic = 0;
    end
  end

  logic prun = 1'b0;
  logic pbusy = 1'b0;
  int cyc = 0;
  int t_fall = 0;
  int len_rise = 0;
  int nb_rise = 0;

  always @(negedge usrclk) begin
    cyc++;
    if (!usrrst_n) begin
      prun = 1'b0;
      pbusy = 1'b0;
    end else begin
      if (test_run_ctrl && !prun) begin
        len_rise = int'(test_len_ctrl);
        nb_rise = nb;
      end
      if (!test_run_ctrl && prun) begin
        t_fall = cyc;
        if (stq.size() == 0) begin
          chk("unexpected_step", int'(test_len_ctrl), -1);
        end else begin
          s = stq.pop_front();
          chk("step_len_rise", len_rise, s.len);
          chk("step_len_fall", int'(test_len_ctrl), s.len);
          if (s.bursts >= 0) chk("step_bursts", nb - nb_rise, s.bursts);
        end
      end
      if (!busy && pbusy) begin
        if (sq.size() == 0) begin
          chk("unexpected_end", int'(step_cnt), -1);
        end else begin
          st = sq.pop_front();
          chk("done", int'(done), st.done);
          chk("err_link", int'(err_link), st.el);
          chk("err_timeout", int'(err_timeout), st.et);
          chk("step_cnt", int'(step_cnt), st.steps);
          chk("final_len", int'(test_len_ctrl), st.len);
          if (st.gap >= 0) chk("gap_cycles", cyc - t_fall, st.gap);
        end
      end
      prun = test_run_ctrl;
      pbusy = busy;
    end
  end

  task automatic cfg_start(input int ls, input int le, input int sp, input int bn);
    @(posedge usrclk);
    #1;
    len_start = 8'(ls);
    len_end = 8'(le);
    len_step = 8'(sp);
    burst_num = 16'(bn);
    start = 1'b1;
    @(posedge usrclk);
    #1;
    start = 1'b0;
    len_start = 8'hAA;
    len_end = 8'h00;
    len_step = 8'h00;
    burst_num = 16'hFFFF;
  endtask

  task automatic wait_idle(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge usrclk);
      if (!busy) break;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_run(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge usrclk);
      if (test_run_ctrl) break;
    end
    chk("run_reached", int'(test_run_ctrl), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int nb0;

  initial begin
    @(negedge usrclk);
    chk("rst_len", int'(test_len_ctrl), 0);
    chk("rst_run", int'(test_run_ctrl), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err_link", int'(err_link), 0);
    chk("rst_err_timeout", int'(err_timeout), 0);
    chk("rst_step_cnt", int'(step_cnt), 0);
    @(posedge usrclk);
    #1;
    usrrst_n = 1'b1;
    link_ready = 1'b1;

    push_step(8, 3);
    push_stat(1, 0, 0, 1, 8, 65);
    cfg_start(8, 8, 4, 3);
    wait_idle(2000);

    push_step(0, 2);
    push_step(8, 2);
    push_step(16, 2);
    push_stat(1, 0, 0, 3, 16, 65);
    cfg_start(0, 20, 8, 2);
    repeat (30) @(posedge usrclk);
    #1;
    start = 1'b1;
    len_start = 8'd100;
    @(posedge usrclk);
    #1;
    start = 1'b0;
    wait_idle(3000);

    push_step(250, 1);
    push_stat(1, 0, 0, 1, 250, 65);
    cfg_start(250, 255, 10, 1);
    wait_idle(2000);

    push_step(5, 1);
    push_stat(1, 0, 0, 1, 5, 65);
    cfg_start(5, 5, 1, 0);
    wait_idle(2000);

    push_step(40, 1);
    push_stat(1, 0, 0, 1, 40, 65);
    cfg_start(40, 10, 5, 1);
    wait_idle(2000);

    link_ready = 1'b0;
    push_step(7, -1);
    push_stat(0, 1, 0, 0, 7, -1);
    cfg_start(7, 30, 1, 3);
    repeat (20) @(negedge usrclk);
    chk("wait_link_run", int'(test_run_ctrl), 0);
    chk("wait_link_busy", int'(busy), 1);
    @(posedge usrclk);
    #1;
    link_ready = 1'b1;
    wait_run(10);
    repeat (5) @(posedge usrclk);
    #1;
    link_ready = 1'b0;
    @(posedge usrclk);
    @(negedge usrclk);
    chk("linkloss_run", int'(test_run_ctrl), 0);
    chk("linkloss_err", int'(err_link), 1);
    @(negedge usrclk);
    chk("linkloss_busy", int'(busy), 0);
    chk("linkloss_done", int'(done), 0);
    link_ready = 1'b1;

    nb0 = nb;
    push_step(3, -1);
    push_stat(0, 0, 0, 0, 3, -1);
    cfg_start(3, 3, 1, 2);
    for (int i = 0; i < 200; i++) begin
      @(posedge usrclk);
      #2;
      if (nb == nb0 + 2) break;
    end
    chk("abort_bursts_seen", nb - nb0, 2);
    @(posedge usrclk);
    #1;
    abort = 1'b1;
    link_ready = 1'b0;
    @(posedge usrclk);
    #1;
    abort = 1'b0;
    link_ready = 1'b1;
    @(negedge usrclk);
    chk("abort_run", int'(test_run_ctrl), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err_link", int'(err_link), 0);
    push_step(3, 2);
    push_stat(1, 0, 0, 1, 3, 65);
    cfg_start(3, 3, 1, 2);
    wait_idle(2000);

    hold = 1'b1;
`ifdef TESTER_GTX_SEQ_TIMEOUT_EN
    push_step(9, 0);
    push_stat(0, 0, 1, 0, 9, -1);
    cfg_start(9, 9, 1, 1);
    wait_idle(400);
`else
    push_step(9, 0);
    push_stat(0, 0, 0, 0, 9, -1);
    cfg_start(9, 9, 1, 1);
    wait_run(10);
    repeat (300) @(negedge usrclk);
    chk("no_wd_run", int'(test_run_ctrl), 1);
    chk("no_wd_busy", int'(busy), 1);
    chk("no_wd_err", int'(err_timeout), 0);
    @(posedge usrclk);
    #1;
    abort = 1'b1;
    @(posedge usrclk);
    #1;
    abort = 1'b0;
    wait_idle(10);
`endif
    hold = 1'b0;

    cfg_start(12, 12, 1, 5);
    wait_run(10);
    @(posedge usrclk);
    #1;
    usrrst_n = 1'b0;
    #1;
    chk("midrst_run", int'(test_run_ctrl), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_len", int'(test_len_ctrl), 0);
    @(posedge usrclk);
    #1;
    usrrst_n = 1'b1;
    repeat (3) @(negedge usrclk);

    chk("step_queue_empty", stq.size(), 0);
    chk("stat_queue_empty", sq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
